// File: rtl/psram_rd_capture_if.sv
// Handshake bundle between psram_rd_capture and its consumer: read-window control,
// PSRAM pad inputs and the assembled read results.
interface psram_rd_capture_if #(
    parameter int DATA_BYTES = 8,
    parameter int TMO_W      = 8
);
    logic                    arm_i;
    logic [3:0]              byte_num_i;
    logic [TMO_W-1:0]        timeout_i;
    logic                    dqs_i;
    logic [7:0]              dq_i;
    logic [8*DATA_BYTES-1:0] rd_data_o;
    logic [7:0]              rd_byte_o;
    logic                    valid_o;
    logic                    err_o;
    logic                    busy_o;

    modport slave (
        input  arm_i, byte_num_i, timeout_i, dqs_i, dq_i,
        output rd_data_o, rd_byte_o, valid_o, err_o, busy_o
    );

    modport master (
        output arm_i, byte_num_i, timeout_i, dqs_i, dq_i,
        input  rd_data_o, rd_byte_o, valid_o, err_o, busy_o
    );
endinterface

// File: rtl/psram_rd_capture.sv
// PSRAM read-data capture: oversamples DQS/DQ, captures one byte per DQS edge (DDR) and
// publishes the assembled burst atomically, with an inter-edge timeout.
module psram_rd_capture #(
    parameter int DATA_BYTES  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TMO_W       = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    psram_rd_capture_if.slave   bus
);
    localparam int DATA_W = 8 * DATA_BYTES;
    localparam int CNT_W  = $clog2(DATA_BYTES + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPT, S_DONE} state_t;

    logic [SYNC_STAGES-1:0]      dqs_sync_q, dqs_sync_d;
    logic [SYNC_STAGES-1:0][7:0] dq_sync_q, dq_sync_d;
    logic                        dqs_prev_q, dqs_prev_d;
    logic                        arm_q, arm_d;
    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d, num_q, num_d, num_clamped;
    logic [TMO_W-1:0]            tmo_q, tmo_d, tmo_inc;
    logic [DATA_W-1:0]           buf_q, buf_d, cap_buf, rd_data_q, rd_data_d;
    logic [7:0]                  rd_byte_q, rd_byte_d, dq_s;
    logic                        valid_q, valid_d, err_q, err_d;
    logic                        dqs_s, dqs_edge, arm_rise, last_byte, tmo_hit;

    // DQ goes through the same depth as DQS so the byte is aligned with its edge.
    assign dqs_s    = dqs_sync_q[SYNC_STAGES-1];
    assign dq_s     = dq_sync_q[SYNC_STAGES-1];
    assign dqs_edge = dqs_s ^ dqs_prev_q;
    assign arm_rise = bus.arm_i & ~arm_q;
    assign tmo_inc  = tmo_q + TMO_W'(1);
    assign tmo_hit  = (bus.timeout_i != '0) && (tmo_inc == bus.timeout_i);
    assign last_byte = (cnt_q + CNT_W'(1)) == num_q;

    always_comb begin
        if (bus.byte_num_i == 4'd0 || 32'(bus.byte_num_i) > DATA_BYTES)
            num_clamped = CNT_W'(DATA_BYTES);
        else
            num_clamped = CNT_W'(bus.byte_num_i);
    end

    always_comb begin
        cap_buf = buf_q;
        for (int k = 0; k < DATA_BYTES; k++) begin
            if (cnt_q == CNT_W'(k))
                cap_buf[8*(DATA_BYTES-k)-1 -: 8] = dq_s;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        dqs_sync_d = {dqs_sync_q[SYNC_STAGES-2:0], bus.dqs_i};
        dq_sync_d  = {dq_sync_q[SYNC_STAGES-2:0], bus.dq_i};
        dqs_prev_d = dqs_s;
        arm_d      = bus.arm_i;
        state_d    = state_q;
        cnt_d      = cnt_q;
        num_d      = num_q;
        tmo_d      = tmo_q;
        buf_d      = buf_q;
        rd_data_d  = rd_data_q;
        rd_byte_d  = rd_byte_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (arm_rise) begin
                    state_d = S_WAIT;
                    num_d   = num_clamped;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    buf_d   = '0;
                end
            end
            S_WAIT, S_CAPT: begin
                if (!bus.arm_i) begin
                    state_d = S_IDLE;
                end else if (dqs_edge) begin
                    // An edge beats a simultaneous timeout.
                    buf_d = cap_buf;
                    cnt_d = cnt_q + CNT_W'(1);
                    tmo_d = '0;
                    if (last_byte) begin
                        state_d   = S_DONE;
                        rd_data_d = cap_buf;
                        rd_byte_d = cap_buf[DATA_W-1 -: 8];
                        valid_d   = 1'b1;
                    end else begin
                        state_d = S_CAPT;
                    end
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_hit) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dqs_sync_q <= '0;
            dq_sync_q  <= '0;
            dqs_prev_q <= 1'b0;
            arm_q      <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            num_q      <= '0;
            tmo_q      <= '0;
            buf_q      <= '0;
            rd_data_q  <= '0;
            rd_byte_q  <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            dqs_sync_q <= dqs_sync_d;
            dq_sync_q  <= dq_sync_d;
            dqs_prev_q <= dqs_prev_d;
            arm_q      <= arm_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            num_q      <= num_d;
            tmo_q      <= tmo_d;
            buf_q      <= buf_d;
            rd_data_q  <= rd_data_d;
            rd_byte_q  <= rd_byte_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign bus.rd_data_o = rd_data_q;
    assign bus.rd_byte_o = rd_byte_q;
    assign bus.valid_o   = valid_q;
    assign bus.err_o     = err_q;
    assign bus.busy_o    = (state_q == S_WAIT) || (state_q == S_CAPT);
endmodule

// File: tb/tb_psram_rd_capture.sv
// Scoreboard bench for psram_rd_capture: bursts push expected words, the valid_o
// monitor pops and compares; timeout, abort and reset cases check pulse counts.
module tb_psram_rd_capture;
    localparam int DB = 8;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  byte0;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   valid_cnt = 0;
    int   err_cnt = 0;
    exp_t sb[$];

    psram_rd_capture_if #(.DATA_BYTES(DB), .TMO_W(8)) bus ();

    psram_rd_capture #(.DATA_BYTES(DB), .SYNC_STAGES(2), .TMO_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.valid_o) begin
            exp_t e;
            valid_cnt++;
            check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rd_data", bus.rd_data_o, e.data);
                check("rd_byte", 64'(bus.rd_byte_o), 64'(e.byte0));
            end
        end
        if (!rst && bus.err_o) err_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic dq_edge(input logic [7:0] b);
        bus.dq_i  = b;
        bus.dqs_i = ~bus.dqs_i;
        tick(2);
    endtask

    task automatic start(input logic [3:0] num, input logic [7:0] tmo);
        bus.byte_num_i = num;
        bus.timeout_i  = tmo;
        bus.arm_i      = 1'b1;
        tick(2);
    endtask

    task automatic stop();
        tick(6);
        bus.arm_i = 1'b0;
        tick(4);
    endtask

    // Expected word: first byte in MSB byte, bytes beyond the clamped count are zero.
    function automatic exp_t model(input logic [7:0] b [DB+2], input int num);
        exp_t e;
        int   eff;
        eff = (num == 0 || num > DB) ? DB : num;
        e.data = '0;
        for (int k = 0; k < eff; k++) e.data[8*(DB-k)-1 -: 8] = b[k];
        e.byte0 = b[0];
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        logic [7:0] b [DB+2];
        int v0, e0, n, num;
        bit found;

        bus.arm_i = 1'b0; bus.byte_num_i = '0; bus.timeout_i = '0;
        bus.dqs_i = 1'b0; bus.dq_i = '0;
        tick(3);
        check("rst_rd_data", bus.rd_data_o, 64'd0);
        check("rst_flags", {59'd0, bus.valid_o, bus.err_o, bus.busy_o, bus.rd_byte_o == 8'd0, 1'b0}, 64'd2);
        rst = 1'b0;
        tick(3);

        // Full 8-byte burst.
        v0 = valid_cnt;
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00, 8'h00};
        sb.push_back('{data: 64'h1122334455667788, byte0: 8'h11});
        start(4'd8, 8'd0);
        check("t1_busy", 64'(bus.busy_o), 64'd1);
        for (int k = 0; k < 8; k++) dq_edge(b[k]);
        stop();
        check("t1_valids", 64'(valid_cnt - v0), 64'd1);
        check("t1_busy_end", 64'(bus.busy_o), 64'd0);

        // Single-byte config read, extra edges while still armed are ignored.
        v0 = valid_cnt;
        sb.push_back('{data: 64'hA500000000000000, byte0: 8'hA5});
        start(4'd1, 8'd0);
        dq_edge(8'hA5);
        dq_edge(8'h5A);
        dq_edge(8'hFF);
        stop();
        check("t2_valids", 64'(valid_cnt - v0), 64'd1);
        check("t2_rd_byte_held", 64'(bus.rd_byte_o), 64'hA5);

        // Timeout after 3 of 8 edges: err pulse about 10 cycles after the third capture.
        v0 = valid_cnt; e0 = err_cnt;
        start(4'd8, 8'd10);
        dq_edge(8'h01);
        dq_edge(8'h02);
        bus.dq_i = 8'h03;
        bus.dqs_i = ~bus.dqs_i;
        n = 0; found = 0;
        while (n < 40 && !found) begin
            tick(1);
            n++;
            if (bus.err_o) found = 1;
        end
        check("t3_err_seen", 64'(found), 64'd1);
        check("t3_err_window", 64'(n >= 11 && n <= 15), 64'd1);
        tick(3);
        check("t3_errs", 64'(err_cnt - e0), 64'd1);
        check("t3_no_valid", 64'(valid_cnt - v0), 64'd0);
        check("t3_data_held", bus.rd_data_o, 64'hA500000000000000);
        check("t3_busy", 64'(bus.busy_o), 64'd0);
        bus.arm_i = 1'b0;
        tick(4);

        // Arm dropped after 4 of 8 bytes: silent abort, then a clean full burst.
        v0 = valid_cnt; e0 = err_cnt;
        start(4'd8, 8'd0);
        for (int k = 0; k < 4; k++) dq_edge(8'hC0 + 8'(k));
        bus.arm_i = 1'b0;
        tick(8);
        check("t4_abort_valid", 64'(valid_cnt - v0), 64'd0);
        check("t4_abort_err", 64'(err_cnt - e0), 64'd0);
        check("t4_abort_busy", 64'(bus.busy_o), 64'd0);
        check("t4_abort_data", bus.rd_data_o, 64'hA500000000000000);
        for (int k = 0; k < DB + 2; k++) b[k] = 8'($urandom);
        sb.push_back(model(b, 8));
        start(4'd8, 8'd0);
        for (int k = 0; k < 8; k++) dq_edge(b[k]);
        stop();
        check("t4_valids", 64'(valid_cnt - v0), 64'd1);

        // byte_num 0 means 8; bytes 9 and 10 must not corrupt the result.
        v0 = valid_cnt;
        for (int k = 0; k < DB + 2; k++) b[k] = 8'($urandom);
        sb.push_back(model(b, 0));
        start(4'd0, 8'd0);
        for (int k = 0; k < 10; k++) dq_edge(b[k]);
        stop();
        check("t5_valids", 64'(valid_cnt - v0), 64'd1);

        // Random-length bursts, including the out-of-range count 12.
        for (int r = 0; r < 4; r++) begin
            v0 = valid_cnt;
            num = (r == 3) ? 12 : $urandom_range(1, 8);
            for (int k = 0; k < DB + 2; k++) b[k] = 8'($urandom);
            sb.push_back(model(b, num));
            start(4'(num), 8'd20);
            for (int k = 0; k < ((num > 8) ? 8 : num); k++) dq_edge(b[k]);
            stop();
            check("rnd_valids", 64'(valid_cnt - v0), 64'd1);
        end

        // Reset in the middle of a capture.
        v0 = valid_cnt; e0 = err_cnt;
        start(4'd8, 8'd0);
        for (int k = 0; k < 3; k++) dq_edge(8'h90 + 8'(k));
        check("t6_busy_before", 64'(bus.busy_o), 64'd1);
        bus.arm_i = 1'b0;
        rst = 1'b1;
        #2;
        check("t6_rst_data", bus.rd_data_o, 64'd0);
        check("t6_rst_flags", {60'd0, bus.valid_o, bus.err_o, bus.busy_o, bus.rd_byte_o != 8'd0}, 64'd0);
        tick(2);
        rst = 1'b0;
        tick(8);
        check("t6_no_pulse", 64'((valid_cnt - v0) + (err_cnt - e0)), 64'd0);
        b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        sb.push_back('{data: 64'hDEADBEEF00000000, byte0: 8'hDE});
        start(4'd4, 8'd0);
        for (int k = 0; k < 4; k++) dq_edge(b[k]);
        stop();
        check("t6_valids", 64'(valid_cnt - v0), 64'd1);

        tick(5);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
